// File: rtl/sap_pkg.sv
// Shared types and constants for the program/data RAM loader.
// Contents: RAM geometry constants, loader counter widths, loader state enum.
package sap_pkg;

    localparam int unsigned RAM_ADDR_W = 4;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 16;
    localparam int unsigned LEN_W      = 5;   // byte count 0..RAM_DEPTH
    localparam int unsigned WE_CNT_W   = 3;   // write-pulse counter, WE_CYCLES 1..7

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_BYTE,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_VERIFY,
        ST_FINISH
    } mem_loader_state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream and RAM-bus bundle between the loader, its byte source and the RAM.
// master: loader side (drives in_ready and the RAM bus, samples stream and read data).
// slave : source/RAM side (drives in_data, in_valid, mem_read_data).
interface mem_loader_if;
    import sap_pkg::*;

    logic [RAM_DATA_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [RAM_ADDR_W-1:0] mem_address;
    logic [RAM_DATA_W-1:0] mem_data;
    logic                  mem_write_enable;
    logic                  mem_enable;
    logic [RAM_DATA_W-1:0] mem_read_data;

    modport master (
        input  in_data, in_valid, mem_read_data,
        output in_ready, mem_address, mem_data, mem_write_enable, mem_enable
    );

    modport slave (
        output in_data, in_valid, mem_read_data,
        input  in_ready, mem_address, mem_data, mem_write_enable, mem_enable
    );

endinterface

// File: rtl/mem_write_strobe.sv
// Write-strobe phaser: after a go pulse, one setup cycle, WE_CYCLES cycles of
// we_n low, then release. phase_done is high during the last low cycle.
// Ports: clk, reset_n (sync, active-low), clear (sync cancel), go -> we_n, phase_done.
module mem_write_strobe
    import sap_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic go,
    output logic we_n,
    output logic phase_done
);

    logic                pending;
    logic [WE_CNT_W-1:0] cnt;

    // pending marks the setup cycle; cnt counts the remaining low cycles
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            pending    <= 1'b0;
            we_n       <= 1'b1;
            cnt        <= '0;
            phase_done <= 1'b0;
        end else begin
            pending <= go;
            if (pending) begin
                we_n       <= 1'b0;
                cnt        <= WE_CNT_W'(WE_CYCLES - 1);
                phase_done <= (WE_CYCLES == 1);
            end else if (!we_n) begin
                if (phase_done) begin
                    we_n       <= 1'b1;
                    phase_done <= 1'b0;
                end else begin
                    cnt        <= cnt - WE_CNT_W'(1);
                    phase_done <= (cnt == WE_CNT_W'(1));
                end
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Loads a byte stream into consecutive RAM addresses with setup/pulse/hold
// write phasing and optional per-byte read-back verification.
// Ports: clk, reset_n (sync, active-low), start/start_addr/length begin a load,
// abort cancels it, bus (stream + RAM bus), busy, done pulse, sticky error, err_addr.
module mem_loader
    import sap_pkg::*;
#(
    parameter int unsigned WE_CYCLES = 2,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [RAM_ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]      length,
    input  logic                  abort,
    mem_loader_if.master          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [RAM_ADDR_W-1:0] err_addr
);

    mem_loader_state_t state, state_next;
    logic [LEN_W-1:0]  count;
    logic              we_n;
    logic              phase_done;
    logic              abort_c;
    logic              start_c;
    logic              accept_c;
    logic              verify_c;
    logic              advance_c;
    logic              last_c;

    mem_write_strobe #(.WE_CYCLES(WE_CYCLES)) u_strobe (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (abort_c),
        .go         (accept_c),
        .we_n       (we_n),
        .phase_done (phase_done)
    );

    assign bus.mem_write_enable = we_n;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next state and per-cycle actions; abort overrides everything
    always_comb begin
        state_next = state;
        abort_c    = abort && (state != ST_IDLE);
        start_c    = 1'b0;
        accept_c   = 1'b0;
        verify_c   = 1'b0;
        advance_c  = 1'b0;
        last_c     = (count == LEN_W'(1));
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    start_c    = 1'b1;
                    state_next = (length == '0) ? ST_FINISH : ST_WAIT_BYTE;
                end
            end
            ST_WAIT_BYTE: begin
                if (bus.in_valid && bus.in_ready) begin
                    accept_c   = 1'b1;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: state_next = ST_WRITE;
            ST_WRITE: begin
                if (phase_done) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (VERIFY) begin
                    state_next = ST_VERIFY;
                end else begin
                    advance_c  = 1'b1;
                    state_next = last_c ? ST_FINISH : ST_WAIT_BYTE;
                end
            end
            ST_VERIFY: begin
                verify_c   = 1'b1;
                advance_c  = 1'b1;
                state_next = last_c ? ST_FINISH : ST_WAIT_BYTE;
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
        if (abort_c) begin
            state_next = ST_IDLE;
            accept_c   = 1'b0;
            verify_c   = 1'b0;
            advance_c  = 1'b0;
        end
    end

    // Registered outputs, address/count, data latch and verify result
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.in_ready    <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            bus.mem_enable  <= 1'b1;
            count           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_addr        <= '0;
        end else begin
            bus.in_ready   <= (state_next == ST_WAIT_BYTE);
            bus.mem_enable <= (state_next != ST_VERIFY);
            busy           <= (state_next != ST_IDLE);
            done           <= (state_next == ST_FINISH);
            if (start_c) begin
                error <= 1'b0;
                if (length != '0) begin
                    bus.mem_address <= start_addr;
                    count           <= length;
                end
            end
            if (accept_c) bus.mem_data <= bus.in_data;
            // only the first mismatch of a load records its address
            if (verify_c && (bus.mem_read_data != bus.mem_data) && !error) begin
                error    <= 1'b1;
                err_addr <= bus.mem_address;
            end
            if (advance_c) begin
                count           <= count - LEN_W'(1);
                bus.mem_address <= bus.mem_address + RAM_ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: RAM model, write-pulse monitor,
// table-driven loads, randomized loads, and abort/zero-length/reset sequences.
module tb_mem_loader;
    import sap_pkg::*;

    localparam int unsigned WE_CYC = 2;

    typedef struct {
        logic [3:0] addr;
        int         len;
        logic [7:0] base;
        logic [7:0] step;
        bit         c_en;
        logic [3:0] c_addr;
        bit         exp_err;
        logic [3:0] exp_ea;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] start_addr = '0;
    logic [4:0] length = '0;
    logic       busy, done, error;
    logic [3:0] err_addr;

    mem_loader_if bus();

    always #5 clk = ~clk;

    mem_loader #(.WE_CYCLES(WE_CYC), .VERIFY(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_addr   (err_addr)
    );

    // RAM model: written while WE is low, combinational read with optional fault
    logic [7:0] ram     [16] = '{default: 8'h00};
    logic [7:0] exp_ram [16] = '{default: 8'h00};
    bit         corrupt_en = 1'b0;
    logic [3:0] corrupt_addr = '0;

    always @(posedge clk) if (!bus.mem_write_enable) ram[bus.mem_address] <= bus.mem_data;
    assign bus.mem_read_data = (corrupt_en && bus.mem_address == corrupt_addr) ? 8'hFF
                                                                              : ram[bus.mem_address];

    // Monitor: pulse width, address/data stability, WE/OE exclusion, done count, write log
    int          pw_viol = 0, stab_viol = 0, inv_viol = 0, done_cnt = 0, width = 0;
    bit          mon_relax = 1'b0;
    bit          prev_we = 1'b1;
    logic [3:0]  prev_a = '0, cur_a = '0;
    logic [7:0]  prev_d = '0, cur_d = '0;
    logic [11:0] wlog [$];

    always @(negedge clk) begin
        if (!bus.mem_write_enable && !bus.mem_enable) inv_viol++;
        if (done) done_cnt++;
        if (!bus.mem_write_enable) begin
            if (prev_we) begin
                width = 1;
                cur_a = bus.mem_address;
                cur_d = bus.mem_data;
                if (!mon_relax && (bus.mem_address != prev_a || bus.mem_data != prev_d)) stab_viol++;
            end else begin
                width++;
                if (bus.mem_address != cur_a || bus.mem_data != cur_d) stab_viol++;
            end
        end else if (!prev_we) begin
            if (!mon_relax) begin
                if (bus.mem_address != cur_a || bus.mem_data != cur_d) stab_viol++;
                if (width != int'(WE_CYC)) pw_viol++;
            end
            wlog.push_back({cur_a, cur_d});
        end
        prev_we = bus.mem_write_enable;
        prev_a  = bus.mem_address;
        prev_d  = bus.mem_data;
    end

    int         checks = 0, errors = 0;
    logic [7:0] load_bytes [16];
    logic [3:0] m_err_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic feed_byte(input logic [7:0] b, input int gmax, output bit ok);
        int n;
        int gap;
        gap = int'($urandom_range(gmax, 0));
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        ok = bus.in_ready;
        if (ok) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
    endtask

    task automatic start_pulse(input logic [3:0] a, input logic [4:0] len);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = len;
        @(posedge clk); #1;
        start = 1'b0; start_addr = 4'($urandom);
    endtask

    task automatic wait_we_low(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.mem_write_enable && n < 20) begin @(negedge clk); n++; end
        ok = !bus.mem_write_enable;
    endtask

    // One full load; expectations come from the address/byte/fault rules
    task automatic run_load(input logic [3:0] a, input int len, input int gmax, input bit poke,
                            input bit c_en, input logic [3:0] c_addr);
        logic [11:0] exp_log [$];
        bit          exp_err;
        bit          ok;
        int          d0, n;
        logic [3:0]  aa;
        logic [7:0]  b;
        corrupt_en   = c_en;
        corrupt_addr = c_addr;
        exp_err      = 1'b0;
        for (int i = 0; i < len; i++) begin
            aa = a + 4'(i);
            b  = load_bytes[i];
            exp_ram[aa] = b;
            exp_log.push_back({aa, b});
            if (!exp_err && c_en && aa == c_addr && b != 8'hFF) begin
                exp_err    = 1'b1;
                m_err_addr = aa;
            end
        end
        wlog.delete();
        d0 = done_cnt;
        start_pulse(a, 5'(len));
        for (int i = 0; i < len; i++) begin
            feed_byte(load_bytes[i], gmax, ok);
            if (!ok) begin check("handshake_wait", 32'd0, 32'd1); break; end
            if (i == 0 && poke) begin
                start = 1'b1; start_addr = 4'($urandom); length = 5'($urandom_range(16, 1));
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 400);
        check("load_idle", 32'(busy), 32'd0);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("error", 32'(error), 32'(exp_err));
        check("err_addr", 32'(err_addr), 32'(m_err_addr));
        check("write_count", 32'(wlog.size()), 32'(len));
        for (int i = 0; i < len && i < wlog.size(); i++)
            check($sformatf("write_seq[%0d]", i), 32'(wlog[i]), 32'(exp_log[i]));
        for (int k = 0; k < 16; k++)
            check($sformatf("ram[%0d]", k), 32'(ram[k]), 32'(exp_ram[k]));
        check("we_pulse_width", 32'(pw_viol), 32'd0);
        check("addr_data_stable", 32'(stab_viol), 32'd0);
        check("we_oe_exclusive", 32'(inv_viol), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(bus.mem_write_enable), 32'd1);
        check({tag, "_oe"}, 32'(bus.mem_enable), 32'd1);
        check({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
        check({tag, "_data"}, 32'(bus.mem_data), 32'd0);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_addr"}, 32'(err_addr), 32'd0);
    endtask

    initial begin
        vec_t tbl [4];
        bit   ok;
        int   d0;

        tbl[0] = '{4'd0,  4,  8'h11, 8'h11, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[1] = '{4'd14, 3,  8'hA0, 8'h01, 1'b0, 4'd0, 1'b0, 4'd0};
        tbl[2] = '{4'd2,  8,  8'h10, 8'h01, 1'b1, 4'd5, 1'b1, 4'd5};
        tbl[3] = '{4'd9,  16, 8'h40, 8'h03, 1'b0, 4'd0, 1'b0, 4'd5};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Directed table
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < tbl[t].len; i++)
                load_bytes[i] = 8'(int'(tbl[t].base) + int'(tbl[t].step) * i);
            run_load(tbl[t].addr, tbl[t].len, (t == 3) ? 2 : 0, 1'b0, tbl[t].c_en, tbl[t].c_addr);
            check($sformatf("tbl%0d_error", t), 32'(error), 32'(tbl[t].exp_err));
            check($sformatf("tbl%0d_err_addr", t), 32'(err_addr), 32'(tbl[t].exp_ea));
        end

        // Randomized loads with stalls, faults and ignored starts
        for (int r = 0; r < 12; r++) begin
            int len;
            len = int'($urandom_range(16, 1));
            for (int i = 0; i < len; i++) load_bytes[i] = 8'($urandom);
            run_load(4'($urandom), len, 3, 1'($urandom), 1'($urandom), 4'($urandom));
        end

        // Abort during WRITE of byte 2 of 5; byte 1 fails verify first
        corrupt_en = 1'b1; corrupt_addr = 4'd3;
        start_pulse(4'd3, 5'd5);
        feed_byte(8'h5A, 0, ok);
        if (!ok) check("abort_hs0", 32'd0, 32'd1);
        feed_byte(8'h6B, 0, ok);
        if (!ok) check("abort_hs1", 32'd0, 32'd1);
        wait_we_low(ok);
        check("abort_in_write", 32'(ok), 32'd1);
        check("abort_write_addr", 32'(bus.mem_address), 32'd4);
        check("abort_write_data", 32'(bus.mem_data), 32'h6B);
        mon_relax = 1'b1;
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(bus.mem_write_enable), 32'd1);
        check("abort_oe", 32'(bus.mem_enable), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd0);
        check("abort_error_kept", 32'(error), 32'd1);
        check("abort_err_addr", 32'(err_addr), 32'd3);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);

        // Zero-length load; a start during FINISH is ignored
        corrupt_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 4'd9; length = 5'd0;
        @(posedge clk); #1;
        length = 5'd3;
        @(negedge clk);
        check("zero_len_done", 32'(done), 32'd1);
        check("zero_len_busy", 32'(busy), 32'd1);
        check("zero_len_error_clr", 32'(error), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("finish_done_end", 32'(done), 32'd0);
        check("finish_start_ignored", 32'(busy), 32'd0);
        check("finish_in_ready", 32'(bus.in_ready), 32'd0);
        check("zero_len_err_addr", 32'(err_addr), 32'd3);

        // Reset during WRITE, start held during reset
        start_pulse(4'd7, 5'd3);
        feed_byte(8'h77, 0, ok);
        if (!ok) check("reset_hs", 32'd0, 32'd1);
        wait_we_low(ok);
        check("reset_in_write", 32'(ok), 32'd1);
        reset_n = 1'b0;
        start = 1'b1; start_addr = 4'd2; length = 5'd4;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        check("rst_start_ignored", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_we", 32'(bus.mem_write_enable), 32'd1);
        check("final_we_oe_exclusive", 32'(inv_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
